// File: rtl/coeff_load_sequencer.sv
// coeff_load_sequencer: clear then NUM_COEFF load/wait handshakes with settle window, restart and status pulses
module coeff_load_sequencer #(
  parameter int NUM_COEFF   = 4,
  parameter int IDX_W       = $clog2(NUM_COEFF),
  parameter int WAIT_SETTLE = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             new_coefficient_set,
  input  logic             modwait,
  output logic             load_coeff,
  output logic [IDX_W-1:0] coefficient_num,
  output logic             clear_coeff,
  output logic             busy,
  output logic             load_done,
  output logic             load_abort
);
  localparam int CW = $clog2(WAIT_SETTLE + 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COEFF - 1);
  localparam logic [CW-1:0] SETTLE = CW'(WAIT_SETTLE);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [IDX_W-1:0] idx, nidx;
  logic [CW-1:0] cnt, ncnt;
  logic go;
  assign load_abort = (state == LOAD || state == WAIT) && new_coefficient_set;
  assign go = cnt >= SETTLE && !modwait;
  always_comb begin
    nxt = IDLE;
    nidx = idx;
    ncnt = cnt;
    case (state)
      IDLE:  nxt = new_coefficient_set ? CLEAR : IDLE;
      CLEAR: begin
        nxt = LOAD;
        nidx = '0;
      end
      LOAD:  begin
        nxt = WAIT;
        ncnt = '0;
      end
      WAIT:  begin
        nxt = !go ? WAIT : idx == LAST ? DONE : LOAD;
        nidx = go && idx != LAST ? idx + 1'b1 : idx;
        ncnt = cnt < SETTLE ? cnt + 1'b1 : cnt;
      end
      DONE:  nxt = new_coefficient_set ? CLEAR : IDLE;
      default: begin
        nxt = IDLE;
        nidx = '0;
        ncnt = '0;
      end
    endcase
    if (load_abort) begin
      nxt = CLEAR;
      nidx = '0;
      ncnt = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      load_coeff <= 1'b0;
      clear_coeff <= 1'b0;
      busy <= 1'b0;
      load_done <= 1'b0;
      coefficient_num <= '0;
    end else begin
      state <= nxt;
      idx <= nidx;
      cnt <= ncnt;
      load_coeff <= nxt == LOAD;
      clear_coeff <= nxt == CLEAR;
      busy <= nxt != IDLE;
      load_done <= nxt == DONE;
      coefficient_num <= (nxt == LOAD || nxt == WAIT) ? nidx : '0;
    end
  end
endmodule

// File: tb/tb_coeff_load_sequencer.sv
// tb_coeff_load_sequencer: table and sequence checks with an expected-output scoreboard
module tb_coeff_load_sequencer;
  logic clk = 0, n_rst = 0, req = 0, mw = 0;
  logic load_coeff, clear_coeff, busy, load_done, load_abort;
  logic [1:0] coefficient_num;
  logic n_rst2 = 0, req2 = 0;
  logic load_coeff2, clear_coeff2, busy2, load_done2, load_abort2;
  logic [2:0] coefficient_num2;
  int total = 0, passed = 0;
  localparam logic [6:0] IDL = 7'b0000000;
  localparam logic [6:0] CLR = 7'b0100100;
  localparam logic [6:0] DN  = 7'b0000110;
  typedef struct {logic r; logic q; logic m; logic [6:0] e;} vec_t;
  typedef struct {string nm; logic [6:0] e;} exp_t;
  vec_t tbl[17];
  exp_t sb[$];
  always #5 clk = ~clk;
  coeff_load_sequencer dut (
    .clk(clk), .n_rst(n_rst), .new_coefficient_set(req), .modwait(mw),
    .load_coeff(load_coeff), .coefficient_num(coefficient_num), .clear_coeff(clear_coeff),
    .busy(busy), .load_done(load_done), .load_abort(load_abort)
  );
  coeff_load_sequencer #(.NUM_COEFF(8), .WAIT_SETTLE(0)) dut8 (
    .clk(clk), .n_rst(n_rst2), .new_coefficient_set(req2), .modwait(1'b0),
    .load_coeff(load_coeff2), .coefficient_num(coefficient_num2), .clear_coeff(clear_coeff2),
    .busy(busy2), .load_done(load_done2), .load_abort(load_abort2)
  );
  function automatic logic [6:0] o(input logic l, input logic c, input logic [1:0] n,
                                   input logic b, input logic d, input logic a);
    return {l, c, n, b, d, a};
  endfunction
  function automatic logic [6:0] ldv(input int k);
    return o(1, 0, 2'(k), 1, 0, 0);
  endfunction
  function automatic logic [6:0] wtv(input int k);
    return o(0, 0, 2'(k), 1, 0, 0);
  endfunction
  function automatic void chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b want %b (ld,clr,num,busy,done,abort)", nm, a, e);
  endfunction
  task automatic step(input logic r, input logic q, input logic m, input logic [6:0] e, input string nm);
    exp_t x;
    @(negedge clk);
    n_rst = r;
    req = q;
    mw = m;
    sb.push_back('{nm, e});
    #1;
    x = sb.pop_front();
    chk(x.nm, {1'b0, load_coeff, clear_coeff, coefficient_num, busy, load_done, load_abort}, {1'b0, x.e});
  endtask
  task automatic run_from(input int k0, input string nm);
    for (int k = k0; k < 4; k++) begin
      step(1, 0, 0, ldv(k), nm);
      step(1, 0, 0, wtv(k), nm);
      step(1, 0, 0, wtv(k), nm);
    end
  endtask
  initial begin
    tbl[0] = '{1, 0, 0, IDL};
    tbl[1] = '{1, 1, 0, IDL};
    tbl[2] = '{1, 0, 0, CLR};
    for (int k = 0; k < 4; k++) begin
      tbl[3 + 3 * k] = '{1, 0, 0, ldv(k)};
      tbl[4 + 3 * k] = '{1, 0, 0, wtv(k)};
      tbl[5 + 3 * k] = '{1, 0, 0, wtv(k)};
    end
    tbl[15] = '{1, 0, 0, DN};
    tbl[16] = '{1, 0, 0, IDL};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 17; i++) step(tbl[i].r, tbl[i].q, tbl[i].m, tbl[i].e, $sformatf("tbl%0d", i));
    step(1, 1, 0, IDL, "mw_req");
    step(1, 0, 0, CLR, "mw_clr");
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, ldv(k), "mw_ld");
      repeat (3) step(1, 0, 1, wtv(k), "mw_hold");
      step(1, 0, 0, wtv(k), "mw_go");
    end
    step(1, 0, 0, DN, "mw_done");
    step(1, 0, 0, IDL, "mw_idle");
    step(1, 1, 0, IDL, "ab_req");
    step(1, 0, 0, CLR, "ab_clr");
    step(1, 0, 0, ldv(0), "ab_ld0");
    step(1, 0, 0, wtv(0), "ab_wt0");
    step(1, 0, 0, wtv(0), "ab_wt0");
    step(1, 0, 0, ldv(1), "ab_ld1");
    step(1, 0, 0, wtv(1), "ab_wt1");
    step(1, 0, 0, wtv(1), "ab_wt1");
    step(1, 0, 0, ldv(2), "ab_ld2");
    step(1, 1, 0, o(0, 0, 2, 1, 0, 1), "ab_wait_abort");
    step(1, 1, 0, CLR, "ab_clr_held");
    step(1, 1, 0, o(1, 0, 0, 1, 0, 1), "ab_load_abort");
    step(1, 0, 0, CLR, "ab_reclr");
    run_from(0, "ab_run");
    step(1, 1, 0, DN, "done_req_no_abort");
    step(1, 0, 0, CLR, "done_restart_clr");
    run_from(0, "dr_run");
    step(1, 0, 0, DN, "dr_done");
    step(1, 0, 0, IDL, "dr_idle");
    step(1, 1, 0, IDL, "rst_req");
    step(1, 0, 0, CLR, "rst_clr");
    step(1, 0, 0, ldv(0), "rst_ld0");
    step(1, 0, 0, wtv(0), "rst_wt0");
    step(1, 0, 0, wtv(0), "rst_wt0");
    step(1, 0, 0, ldv(1), "rst_ld1");
    step(0, 0, 0, wtv(1), "rst_in_wait");
    step(1, 0, 0, IDL, "rst_all_zero");
    step(1, 1, 0, IDL, "rst_rereq");
    step(1, 0, 0, CLR, "rst_reclr");
    run_from(0, "rst_run");
    step(1, 0, 0, DN, "rst_done");
    step(1, 0, 0, IDL, "rst_idle");
    step(1, 1, 0, IDL, "long_req");
    step(1, 0, 0, CLR, "long_clr");
    step(1, 0, 0, ldv(0), "long_ld0");
    step(1, 0, 0, wtv(0), "long_settle");
    repeat (100) step(1, 0, 1, wtv(0), "long_hold");
    step(1, 0, 0, wtv(0), "long_release");
    run_from(1, "long_run");
    step(1, 0, 0, DN, "long_done");
    step(1, 0, 0, IDL, "long_idle");
    @(negedge clk);
    n_rst2 = 1;
    req2 = 1;
    #1;
    chk("n8_reset", {load_coeff2, clear_coeff2, coefficient_num2, busy2, load_done2, load_abort2}, 8'h00);
    for (int c = 1; c <= 19; c++) begin
      logic l, cl, b, d;
      logic [2:0] n;
      @(negedge clk);
      req2 = 0;
      #1;
      cl = c == 1;
      l = c >= 2 && c <= 16 && c % 2 == 0;
      n = l ? 3'((c - 2) / 2) : (c >= 3 && c <= 17 && c % 2 == 1) ? 3'((c - 3) / 2) : 3'd0;
      b = c >= 1 && c <= 18;
      d = c == 18;
      chk($sformatf("n8_c%0d", c), {load_coeff2, clear_coeff2, coefficient_num2, busy2, load_done2, load_abort2},
          {l, cl, n, b, d, 1'b0});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
